// File: rtl/fifo_pkt_reader_if.sv
// FIFO read port plus valid/ready streaming source, bundled for fifo_pkt_reader.
// The master modport is the reader's view; the slave modport is the FIFO/sink side.
interface fifo_pkt_reader_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] fifo_q_i;
    logic              fifo_empty_i;
    logic              fifo_rdreq_o;
    logic [DWIDTH-1:0] src_data_o;
    logic              src_valid_o;
    logic              src_ready_i;
    logic              src_startofpacket_o;
    logic              src_endofpacket_o;

    modport master (
        input  fifo_q_i, fifo_empty_i, src_ready_i,
        output fifo_rdreq_o, src_data_o, src_valid_o,
               src_startofpacket_o, src_endofpacket_o
    );

    modport slave (
        output fifo_q_i, fifo_empty_i, src_ready_i,
        input  fifo_rdreq_o, src_data_o, src_valid_o,
               src_startofpacket_o, src_endofpacket_o
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops a show-ahead FIFO into a 2-entry skid buffer and streams fixed-length
// packets with sop/eop; an enable FSM only stops on packet boundaries.
module fifo_pkt_reader #(
    parameter int DWIDTH  = 16,
    parameter int PKT_LEN = 8,
    parameter int CWIDTH  = $clog2(PKT_LEN),
    parameter int PCWIDTH = 16
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic               enable_i,
    fifo_pkt_reader_if.master  bus,
    output logic [PCWIDTH-1:0] pkt_cnt_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [CWIDTH-1:0] LAST = CWIDTH'(PKT_LEN - 1);

    state_t                       state_q, state_d;
    logic [1:0]                   buf_cnt_q, buf_cnt_d;
    logic [1:0][DWIDTH-1:0]       buf_data_q, buf_data_d;
    logic [CWIDTH-1:0]            pop_cnt_q, pop_cnt_d;
    logic [CWIDTH-1:0]            out_cnt_q, out_cnt_d;
    logic [PCWIDTH-1:0]           pkt_cnt_q, pkt_cnt_d;

    logic pop_allowed, pop, valid, xfer, sop, eop;

    // Pop decision uses only registered state and the empty flag, so src_ready_i
    // never reaches fifo_rdreq_o combinationally.
    always_comb begin
        pop_allowed = (state_q == RUN) || (state_q == FINISH && pop_cnt_q != '0);
        pop         = pop_allowed && !bus.fifo_empty_i && (buf_cnt_q < 2'd2);
        valid       = (buf_cnt_q != 2'd0);
        xfer        = valid && bus.src_ready_i;
        sop         = (out_cnt_q == '0);
        eop         = (out_cnt_q == LAST);
    end

    // Slot 0 is always the head; a transfer shifts slot 1 down before any pop lands.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_cnt_d  = buf_cnt_q;
        if (xfer) begin
            buf_data_d[0] = buf_data_q[1];
            buf_cnt_d     = buf_cnt_q - 2'd1;
        end
        if (pop) begin
            buf_data_d[buf_cnt_d[0]] = bus.fifo_q_i;
            buf_cnt_d                = buf_cnt_d + 2'd1;
        end
    end

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (pop) pop_cnt_d = (pop_cnt_q == LAST) ? '0 : pop_cnt_q + CWIDTH'(1);
        out_cnt_d = out_cnt_q;
        if (xfer) out_cnt_d = (out_cnt_q == LAST) ? '0 : out_cnt_q + CWIDTH'(1);
        pkt_cnt_d = pkt_cnt_q;
        if (xfer && eop) pkt_cnt_d = pkt_cnt_q + PCWIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i) state_d = FINISH;
            FINISH: begin
                if (enable_i)
                    state_d = RUN;
                else if (pop_cnt_q == '0 && buf_cnt_q == 2'd0 && !pop)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            buf_cnt_q <= 2'd0;
            pop_cnt_q <= '0;
            out_cnt_q <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_cnt_q <= buf_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            out_cnt_q <= out_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        buf_data_q <= buf_data_d;
    end

    always_comb begin
        bus.fifo_rdreq_o        = pop;
        bus.src_data_o          = buf_data_q[0];
        bus.src_valid_o         = valid;
        bus.src_startofpacket_o = valid && sop;
        bus.src_endofpacket_o   = valid && eop;
        pkt_cnt_o               = pkt_cnt_q;
        busy_o                  = (state_q != IDLE) || valid;
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: a queue-backed show-ahead FIFO model,
// directed phases pushing expected words, and a monitor checking every transfer.
module tb_fifo_pkt_reader;
    localparam int DW = 16;
    localparam int PL = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } exp_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          enable;
    logic [15:0]   pkt_cnt;
    logic          busy;

    fifo_pkt_reader_if #(.DWIDTH(DW)) bus ();

    fifo_pkt_reader #(.DWIDTH(DW), .PKT_LEN(PL), .PCWIDTH(16)) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .enable_i  (enable),
        .bus       (bus),
        .pkt_cnt_o (pkt_cnt),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_mem[$];
    exp_t          exp_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ph_pops, ph_first_pop, ph_last_pop, ph_first_vld, ph_vld_cnt;
    int ph_run, ph_run_max, gap, gap_max;
    bit seen_vld;
    logic [1:0] bmax;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fifo_add(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_mem.push_back(base + DW'(i));
    endtask

    task automatic exp_add(input logic [DW-1:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d   = base + DW'(i);
            e.sop = ((i % PL) == 0);
            e.eop = ((i % PL) == PL - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic reset_ph();
        ph_pops = 0; ph_first_pop = -1; ph_last_pop = -1;
        ph_first_vld = -1; ph_vld_cnt = 0; ph_run = 0; ph_run_max = 0;
        gap = 0; gap_max = 0; seen_vld = 1'b0; bmax = 2'd0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        chk(name, exp_q.size(), 0);
    endtask

    // FIFO model: pop the word the DUT consumed at the last edge, then re-present the head.
    bit pop_pend;
    initial begin
        pop_pend = 1'b0;
        bus.fifo_empty_i = 1'b1;
        bus.fifo_q_i = '0;
        forever begin
            @(negedge clk);
            #1;
            if (pop_pend && fifo_mem.size() > 0) void'(fifo_mem.pop_front());
            bus.fifo_empty_i = (fifo_mem.size() == 0);
            bus.fifo_q_i     = (fifo_mem.size() > 0) ? fifo_mem[0] : '0;
            #3;
            pop_pend = bus.fifo_rdreq_o;
            if (pop_pend) begin
                ph_pops++;
                if (ph_first_pop < 0) ph_first_pop = cyc;
                ph_last_pop = cyc;
            end
            cyc++;
        end
    end

    // Monitor: transfers against the scoreboard, plus hold stability under backpressure.
    initial begin
        bit   hold_v;
        exp_t hold_w, cur, e;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            cur = {bus.src_data_o, bus.src_startofpacket_o, bus.src_endofpacket_o};
            if (srst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", {31'd0, bus.src_valid_o}, 1);
                    chk("hold_word", cur, hold_w);
                end
                if (bus.src_valid_o && bus.src_ready_i) begin
                    chk("xfer_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("xfer_word", cur, e);
                    end
                end
                hold_v = bus.src_valid_o && !bus.src_ready_i;
                hold_w = cur;
            end
            if (bus.src_valid_o) begin
                ph_vld_cnt++;
                if (ph_first_vld < 0) ph_first_vld = cyc;
                ph_run++;
                if (ph_run > ph_run_max) ph_run_max = ph_run;
                seen_vld = 1'b1;
                gap = 0;
            end else begin
                ph_run = 0;
                if (seen_vld && exp_q.size() != 0) begin
                    gap++;
                    if (gap > gap_max) gap_max = gap;
                end
            end
            if (dut.buf_cnt_q > bmax) bmax = dut.buf_cnt_q;
        end
    end

    initial begin
        srst = 1'b1; enable = 1'b0; bus.src_ready_i = 1'b1;
        reset_ph();
        repeat (2) @(negedge clk);
        srst = 1'b0;

        // Idle with a loaded FIFO: nothing moves.
        fifo_add(16'h0101, 20);
        repeat (10) begin
            @(negedge clk); #2;
            chk("idle_outputs", {27'd0, bus.src_valid_o, bus.fifo_rdreq_o,
                bus.src_startofpacket_o, bus.src_endofpacket_o, busy}, 0);
            chk("idle_pkt_cnt", pkt_cnt, 0);
        end
        chk("idle_fifo_untouched", fifo_mem.size(), 20);
        @(negedge clk);
        fifo_mem.delete();

        // One packet, ready held high.
        @(negedge clk);
        reset_ph();
        fifo_add(16'h0001, 8); exp_add(16'h0001, 8);
        enable = 1'b1;
        wait_drained("p1_drained", 60);
        chk("p1_pops", ph_pops, 8);
        chk("p1_pops_consecutive", ph_last_pop - ph_first_pop, 7);
        chk("p1_latency", ph_first_vld - ph_first_pop, 1);
        chk("p1_valid_cycles", ph_vld_cnt, 8);
        chk("p1_valid_run", ph_run_max, 8);
        chk("p1_pkt_cnt", pkt_cnt, 1);

        // Backpressure: ready pattern 1,0,0,1.
        @(negedge clk);
        reset_ph();
        fifo_add(16'h0201, 16); exp_add(16'h0201, 16);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            bus.src_ready_i = ((k % 4) == 0) || ((k % 4) == 3);
        end
        bus.src_ready_i = 1'b1;
        wait_drained("p2_drained", 10);
        chk("p2_pops", ph_pops, 16);
        chk("p2_buf_le2", {30'd0, bmax}, 2);
        chk("p2_pkt_cnt", pkt_cnt, 3);

        // Drop enable after the 3rd pop: the packet still completes.
        @(negedge clk);
        reset_ph();
        fifo_add(16'h0301, 12); exp_add(16'h0301, 8);
        for (int i = 0; i < 40 && ph_pops < 3; i++) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (!busy) break;
        end
        chk("p3_busy_clear", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("p3_pops", ph_pops, 8);
        chk("p3_fifo_left", fifo_mem.size(), 4);
        chk("p3_rdreq_idle", {31'd0, bus.fifo_rdreq_o}, 0);
        chk("p3_state_idle", {30'd0, dut.state_q}, 0);
        chk("p3_drained", exp_q.size(), 0);
        chk("p3_pkt_cnt", pkt_cnt, 4);
        @(negedge clk);
        fifo_mem.delete();

        // FIFO runs dry after 5 words; the rest arrive later.
        @(negedge clk);
        reset_ph();
        enable = 1'b1;
        fifo_add(16'h0401, 5); exp_add(16'h0401, 8);
        for (int i = 0; i < 40 && fifo_mem.size() != 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        fifo_add(16'h0406, 3);
        wait_drained("p4_drained", 60);
        chk("p4_gap_ge3", (gap_max >= 3), 1);
        chk("p4_pkt_cnt", pkt_cnt, 5);

        // Reset with two words buffered mid-packet.
        @(negedge clk);
        reset_ph();
        bus.src_ready_i = 1'b0;
        fifo_add(16'h0501, 3);
        repeat (5) @(negedge clk);
        #2;
        chk("p5_buf_full_valid", {31'd0, bus.src_valid_o}, 1);
        chk("p5_buf_full_rdreq", {31'd0, bus.fifo_rdreq_o}, 0);
        chk("p5_fifo_left", fifo_mem.size(), 1);
        @(negedge clk);
        srst = 1'b1; enable = 1'b0;
        @(negedge clk);
        srst = 1'b0;
        #2;
        chk("p5_rst_valid", {31'd0, bus.src_valid_o}, 0);
        chk("p5_rst_pkt_cnt", pkt_cnt, 0);
        chk("p5_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        fifo_mem.delete();
        fifo_add(16'h0601, 8); exp_add(16'h0601, 8);
        bus.src_ready_i = 1'b1;
        enable = 1'b1;
        wait_drained("p5_drained", 60);
        chk("p5_pkt_cnt", pkt_cnt, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
